// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: walks every input combination of an N-input gate, holds each
// for DWELL cycles, samples the gate output and scores it against the selected function.
module gate_tt_sequencer #(
    parameter int N_IN  = 3,
    parameter int DWELL = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func,
    input  logic            dut_y,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            cfg_err,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec
);
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    state_t          state, state_d;
    logic [2:0]      func_q, func_d;
    logic [7:0]      cnt, cnt_d;
    logic [N_IN-1:0] vec_d, fail_d;
    logic [N_IN:0]   err_d;
    logic            pass_d, cfg_d, exp_y;
    assign busy = state == DRIVE;
    assign done = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            func_q    <= '0;
            cnt       <= '0;
            vec       <= '0;
            fail_vec  <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_d;
            func_q    <= func_d;
            cnt       <= cnt_d;
            vec       <= vec_d;
            fail_vec  <= fail_d;
            err_count <= err_d;
            pass      <= pass_d;
            cfg_err   <= cfg_d;
        end
    end
    always_comb begin
        exp_y   = func_q == 3'd0 ? &vec : func_q == 3'd1 ? |vec : func_q == 3'd2 ? ~&vec :
                  func_q == 3'd3 ? ~|vec : func_q == 3'd4 ? ^vec : ~^vec;
        state_d = state;
        func_d  = func_q;
        cnt_d   = cnt;
        vec_d   = vec;
        fail_d  = fail_vec;
        err_d   = err_count;
        pass_d  = pass;
        cfg_d   = cfg_err;
        case (state)
            IDLE: begin
                vec_d = '0;
                if (start) begin
                    func_d  = func;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                    cfg_d   = func[2] & func[1];
                    cnt_d   = '0;
                    state_d = (func[2] & func[1]) ? DONE : DRIVE;
                end
            end
            DRIVE: begin
                cnt_d = cnt + 8'd1;
                if (cnt == 8'(DWELL - 1)) begin
                    if (dut_y != exp_y) begin
                        err_d  = err_count + 1'b1;
                        fail_d = err_count == '0 ? vec : fail_vec;
                    end
                    // pass is settled on the final sample edge so it is valid alongside done
                    if (&vec) begin
                        state_d = DONE;
                        pass_d  = err_d == '0;
                    end else begin
                        vec_d = vec + 1'b1;
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                vec_d   = '0;
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_gate_tt_sequencer.sv
// tb_gate_tt_sequencer: directed truth-table runs against behavioural gate models.
module tb_gate_tt_sequencer;
    logic       clk = 1'b0, rst = 1'b1;
    logic       start = 1'b0, start1 = 1'b0;
    logic [2:0] func = 3'd3, func1 = 3'd5;
    int         mode = 0;
    logic       dut_y, dut_y1;
    logic [2:0] vec, fail_vec, vec1, fail_vec1;
    logic [3:0] err_count, err_count1;
    logic       busy, done, pass, cfg_err, busy1, done1, pass1, cfg_err1;
    int         n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    // 0 correct NOR, 1 OR (inverted), 2 stuck-at-0, 3 stuck-at-1
    assign dut_y  = mode == 0 ? ~|vec : mode == 1 ? |vec : mode == 3;
    assign dut_y1 = ~^vec1;
    gate_tt_sequencer #(.N_IN(3), .DWELL(10)) u_dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .dut_y(dut_y), .vec(vec),
        .busy(busy), .done(done), .pass(pass), .cfg_err(cfg_err),
        .err_count(err_count), .fail_vec(fail_vec));
    gate_tt_sequencer #(.N_IN(3), .DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .func(func1), .dut_y(dut_y1), .vec(vec1),
        .busy(busy1), .done(done1), .pass(pass1), .cfg_err(cfg_err1),
        .err_count(err_count1), .fail_vec(fail_vec1));
    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic run(input string tag, input int m, input logic [2:0] f, input int e_done,
                       input int e_busy, input int e_vec11, input int e_vor, input int e_err,
                       input int e_fail, input int e_pass, input int e_cfg);
        int c, busy_n, done_c, v11, vor;
        mode = m;
        func = f;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        c = 1; busy_n = 0; done_c = 0; v11 = 0; vor = 0;
        while (c <= 300 && done_c == 0) begin
            busy_n += int'(busy);
            vor |= int'(vec);
            if (done) done_c = c;
            if (c == 11) v11 = int'(vec);
            if (c == 20) func = 3'd0;
            @(negedge clk);
            c++;
        end
        check({tag, " done_cycle"}, done_c, e_done);
        check({tag, " busy_cycles"}, busy_n, e_busy);
        check({tag, " vec_at_11"}, v11, e_vec11);
        check({tag, " vec_seen"}, vor, e_vor);
        check({tag, " done_pulse_len"}, int'(done), 0);
        check({tag, " err_count"}, int'(err_count), e_err);
        check({tag, " fail_vec"}, int'(fail_vec), e_fail);
        check({tag, " pass"}, int'(pass), e_pass);
        check({tag, " cfg_err"}, int'(cfg_err), e_cfg);
        check({tag, " vec_idle"}, int'(vec), 0);
    endtask
    initial begin
        int n_done, first_done;
        repeat (2) @(negedge clk);
        check("reset outputs", int'({vec, busy, done, pass, cfg_err, err_count, fail_vec}), 0);
        rst = 1'b0;
        @(negedge clk);
        run("nor_ok",  0, 3'd3, 81, 80, 1, 7, 0, 0, 1, 0);
        run("or_dut",  1, 3'd3, 81, 80, 1, 7, 8, 0, 0, 0);
        run("stuck0",  2, 3'd3, 81, 80, 1, 7, 1, 0, 0, 0);
        run("stuck1",  3, 3'd3, 81, 80, 1, 7, 7, 1, 0, 0);
        run("reserved", 0, 3'd6, 1, 0, 0, 0, 0, 0, 0, 1);
        mode = 0;
        func = 3'd3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (34) @(negedge clk);
        check("abort vec_before", int'(vec), 3);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("abort outputs", int'({vec, busy, done, pass, cfg_err, err_count, fail_vec}), 0);
        n_done = 0;
        repeat (100) begin
            n_done += int'(done);
            @(negedge clk);
        end
        check("abort no_done", n_done, 0);
        run("after_abort", 0, 3'd3, 81, 80, 1, 7, 0, 0, 1, 0);
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        n_done = 0; first_done = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 8) check($sformatf("dw1 vec_c%0d", c), int'(vec1), c - 1);
            if (done1) begin
                n_done++;
                if (first_done == 0) first_done = c;
            end
            start1 = c == 4;
            @(negedge clk);
        end
        check("dw1 done_cycle", first_done, 9);
        check("dw1 done_count", n_done, 1);
        check("dw1 pass", int'(pass1), 1);
        check("dw1 err_count", int'(err_count1), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
